// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adder_seq_ctrl: multi-chunk adder sequenced over one shared W-bit      |
// | ripple slice, two requesters via round-robin. Option: ADDSEQ_SUB_EN.   |
// | Revision: 1.0                                                          |
// +-------------------------------------------------------------------------+

module adder_slice #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] w_c;

    assign w_c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    assign cout = w_c[W];
endmodule

module adder_seq_ctrl #(
    parameter int W      = 11,
    parameter int CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*W*CHUNKS-1:0] req_a,
    input  logic [2*W*CHUNKS-1:0] req_b,
    input  logic [1:0]            req_cin,
    input  logic [1:0]            req_sub,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [W*CHUNKS-1:0]   resp_sum,
    output logic                  resp_cout,
    output logic                  busy
);
    localparam int N  = W * CHUNKS;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_last_grant;
    logic [CW-1:0]             r_chunk_idx;
    logic                      r_carry;
    logic [CHUNKS-1:0][W-1:0]  r_a;
    logic [CHUNKS-1:0][W-1:0]  r_b;
    logic [CHUNKS-1:0][W-1:0]  r_sum;
    logic                      r_cout;
    logic                      r_valid;
    logic                      r_id;
    logic                      r_busy;

    logic [1:0]   w_grant;
    logic         w_gsel;
    logic         w_hs;
    logic [N-1:0] w_a_sel;
    logic [N-1:0] w_b_sel;
    logic         w_cin_sel;
    logic [W-1:0] w_ssum;
    logic         w_scout;

    // Grant only while idle; on contention favour the requester not served last.
    always_comb begin
        w_grant = 2'b00;
        w_gsel  = 1'b0;
        if (r_state == S_IDLE) begin
            case (req_valid)
                2'b01: begin w_grant = 2'b01; w_gsel = 1'b0; end
                2'b10: begin w_grant = 2'b10; w_gsel = 1'b1; end
                2'b11: begin
                    w_gsel  = ~r_last_grant;
                    w_grant = r_last_grant ? 2'b01 : 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign w_hs      = |(req_valid & w_grant);
    assign w_a_sel   = w_gsel ? req_a[2*N-1:N] : req_a[N-1:0];
    assign w_b_sel   = w_gsel ? req_b[2*N-1:N] : req_b[N-1:0];
    assign w_cin_sel = req_cin[w_gsel];

`ifdef ADDSEQ_SUB_EN
    logic w_sub_sel;
    assign w_sub_sel = req_sub[w_gsel];
`else
    logic w_unused_sub;
    assign w_unused_sub = ^req_sub;
`endif

    adder_slice #(.W(W)) u_slice (
        .a    (r_a[r_chunk_idx]),
        .b    (r_b[r_chunk_idx]),
        .cin  (r_carry),
        .sum  (w_ssum),
        .cout (w_scout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_chunk_idx  <= '0;
            r_carry      <= 1'b0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_valid      <= 1'b0;
            r_id         <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_a          <= w_a_sel;
`ifdef ADDSEQ_SUB_EN
                        // Subtraction as A + ~B + 1; the requester's carry-in is dropped.
                        r_b          <= w_sub_sel ? ~w_b_sel : w_b_sel;
                        r_carry      <= w_sub_sel | w_cin_sel;
`else
                        r_b          <= w_b_sel;
                        r_carry      <= w_cin_sel;
`endif
                        r_id         <= w_gsel;
                        r_last_grant <= w_gsel;
                        r_chunk_idx  <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_chunk_idx] <= w_ssum;
                    r_carry            <= w_scout;
                    r_chunk_idx        <= r_chunk_idx + 1'b1;
                    if (r_chunk_idx == CW'(CHUNKS - 1)) begin
                        r_cout  <= w_scout;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = r_valid;
    assign resp_id    = r_id;
    assign resp_sum   = r_sum;
    assign resp_cout  = r_cout;
    assign busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// Directed bench for adder_seq_ctrl (W=11, CHUNKS=4); covers the ADDSEQ_SUB_EN
// build and the default build with separate expectations.
module tb_adder_seq_ctrl;
    localparam int W = 11;
    localparam int CHUNKS = 4;
    localparam int N = W * CHUNKS;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [1:0]     req_cin;
    logic [1:0]     req_sub;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [N-1:0]   resp_sum;
    logic           resp_cout;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.W(W), .CHUNKS(CHUNKS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic id, input logic [N-1:0] sum,
                            input logic cout);
        chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_id"}, 64'(resp_id), 64'(id));
        chk({tag, "_sum"}, 64'(resp_sum), 64'(sum));
        chk({tag, "_cout"}, 64'(resp_cout), 64'(cout));
    endtask

    logic [N-1:0] exp_sum [2];
    logic         exp_cout [2];
    logic         g;

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0;
        req_cin = 2'b00; req_sub = 2'b00; resp_ready = 1'b0;

        // Reset and idle
        tick(2);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_sum", 64'(resp_sum), 64'd0);
        chk("rst_cout", 64'(resp_cout), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("idle_ready", 64'(req_ready), 64'd0);

        // Full carry chain from chunk 0 to the top
        req_a[N-1:0] = 44'hFFF_FFFF_FFFF; req_b[N-1:0] = 44'h1; req_valid = 2'b01;
        #1 chk("cc_ready", 64'(req_ready), 64'b01);
        tick(1);
        req_valid = 2'b00; req_a = '0;   // post-capture changes must be ignored
        chk("cc_busy", 64'(busy), 64'd1);
        chk("cc_run_ready", 64'(req_ready), 64'd0);
        tick(3);
        chk("cc_not_yet", 64'(resp_valid), 64'd0);
        tick(1);
        chk_resp("cc", 1'b0, 44'h0, 1'b1);
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;
        chk("cc_exit_valid", 64'(resp_valid), 64'd0);
        chk("cc_exit_busy", 64'(busy), 64'd0);

        // Simple add from requester 1, then back-pressure in DONE
        req_a[2*N-1:N] = 44'h123_4567_89AB; req_b[2*N-1:N] = 44'h111_1111_1111;
        req_cin = 2'b10; req_valid = 2'b10;
        #1 chk("add_ready", 64'(req_ready), 64'b10);
        tick(5);
        req_valid = 2'b11;
        chk_resp("add", 1'b1, 44'h234_5678_9ABD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_sum", 64'(resp_sum), 64'h234_5678_9ABD);
            chk("bp_valid", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        tick(1);
        chk("bp_exit_valid", 64'(resp_valid), 64'd0);
        chk("bp_exit_busy", 64'(busy), 64'd0);
        chk("bp_regrant", 64'(req_ready), 64'b01);

        // Round-robin with both requesters valid and the consumer always ready
        req_a = {44'h0AA_AAAA_AAAA, 44'h800_0000_0000};
        req_b = {44'h055_5555_5555, 44'h800_0000_0000};
        req_cin = 2'b00;
        exp_sum[0] = 44'h0; exp_cout[0] = 1'b1;
        exp_sum[1] = 44'h0FF_FFFF_FFFF; exp_cout[1] = 1'b0;
        g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", 64'(req_ready), g ? 64'b10 : 64'b01);
            tick(5);
            chk_resp("rr", g, exp_sum[g], exp_cout[g]);
            tick(1);
            g = ~g;
        end
        req_valid = 2'b00; resp_ready = 1'b0;

        // Reset while RUN is on chunk 2
        req_a[N-1:0] = 44'h3; req_b[N-1:0] = 44'h4; req_valid = 2'b01;
        tick(3);
        req_valid = 2'b00;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_resp", 64'(resp_valid), 64'd0);
            tick(1);
        end
        req_valid = 2'b11;
        #1 chk("mid_lastgrant", 64'(req_ready), 64'b01);

        // Subtract select on requester 0 with A=5, B=7
        req_a[N-1:0] = 44'h5; req_b[N-1:0] = 44'h7; req_sub = 2'b01; req_cin = 2'b00;
        req_valid = 2'b01;
        tick(1);
        req_valid = 2'b00;
        tick(4);
`ifdef ADDSEQ_SUB_EN
        chk_resp("sub", 1'b0, 44'hFFF_FFFF_FFFE, 1'b0);
`else
        chk_resp("nosub", 1'b0, 44'hC, 1'b0);
`endif
        resp_ready = 1'b1;
        tick(1);
        chk("sub_exit", 64'(resp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
